// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: sequences an external T flip-flop bank as a loadable up/down counter stopping at term_val
//   clk      rising-edge clock shared with the bank
//   rst      asynchronous active-low reset
//   start    begin counting (IDLE/DONE)
//   stop     abort counting (RUN)
//   dir      0 up, 1 down, captured when start is accepted
//   load_en  load load_val into the bank (IDLE/DONE)
//   load_val value forced into the bank
//   term_val terminal value ending RUN
//   q_bank   bank q outputs
//   t_bank   bank t inputs
//   busy     in LOAD or RUN
//   done     in DONE
//   tc       terminal-count strobe
//   run_cnt  cycles spent counting in the last/current RUN
module tff_counter_ctrl #(
   parameter int W  = 4,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          dir,
   input  logic          load_en,
   input  logic [W-1:0]  load_val,
   input  logic [W-1:0]  term_val,
   input  logic [W-1:0]  q_bank,
   output logic [W-1:0]  t_bank,
   output logic          busy,
   output logic          done,
   output logic          tc,
   output logic [CW-1:0] run_cnt
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state;
   logic dir_r, hit, step;
   logic [W-1:0] t_up, t_dn;
   assign hit  = q_bank == term_val;
   assign step = state == RUN && !stop && !hit;
   assign t_up[0] = 1'b1;
   assign t_dn[0] = 1'b1;
   // a bit toggles when all lower bits are 1 (up) or all 0 (down)
   for (genvar i = 1; i < W; i++) begin : g_t
      assign t_up[i] = &q_bank[i-1:0];
      assign t_dn[i] = ~|q_bank[i-1:0];
   end
   // LOAD toggles exactly the bits that differ, so the bank lands on load_val
   always_comb t_bank = state == LOAD ? q_bank ^ load_val : step ? (dir_r ? t_dn : t_up) : '0;
   assign busy = state == LOAD || state == RUN;
   assign done = state == DONE;
   assign tc   = state == RUN && !stop && hit;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         dir_r   <= 1'b0;
         run_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (load_en) state <= LOAD;
               else if (start) begin
                  state   <= RUN;
                  dir_r   <= dir;
                  run_cnt <= '0;
               end
            end
            LOAD: state <= IDLE;
            RUN: begin
               if (stop) state <= IDLE;
               else if (hit) state <= DONE;
               else run_cnt <= run_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb_tff_counter_ctrl: scoreboard bench for tff_counter_ctrl driving a modelled T flip-flop bank
module tb_tff_counter_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, stop = 1'b0, dir = 1'b0, load_en = 1'b0;
   logic [3:0] load_val = '0, term_val = '0;
   logic [3:0] q_bank = '0;
   logic [3:0] t_bank;
   logic busy, done, tc;
   logic [7:0] run_cnt;
   int checks = 0;
   int errors = 0;
   logic [3:0] bank_exp = '0;
   typedef struct {
      logic [3:0] q;
      logic [3:0] t;
      logic tc;
   } exp_t;
   exp_t sb[$];
   tff_counter_ctrl #(.W(4), .CW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
      .load_en(load_en), .load_val(load_val), .term_val(term_val),
      .q_bank(q_bank), .t_bank(t_bank), .busy(busy), .done(done),
      .tc(tc), .run_cnt(run_cnt)
   );
   always #5 clk = ~clk;
   always @(posedge clk) q_bank <= q_bank ^ t_bank;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic do_load(input logic [3:0] v, input logic st);
      @(negedge clk);
      load_en = 1'b1;
      start = st;
      load_val = v;
      @(negedge clk);
      load_en = 1'b0;
      start = 1'b0;
      #1;
      chk("load_busy", busy, 1);
      chk("load_t", t_bank, bank_exp ^ v);
      @(negedge clk);
      #1;
      chk("load_q", q_bank, v);
      chk("load_idle", busy, 0);
      chk("load_t0", t_bank, 0);
      bank_exp = v;
   endtask
   task automatic run_case(input logic ld, input logic [3:0] l, input logic [3:0] t, input logic d, input int stop_at);
      logic [3:0] q, nq;
      int k;
      logic stopped;
      exp_t e;
      if (ld) do_load(l, 1'b0);
      q = bank_exp;
      k = 0;
      stopped = 1'b0;
      while (1) begin
         if (k == stop_at) begin
            sb.push_back('{q, 4'h0, 1'b0});
            stopped = 1'b1;
            break;
         end
         if (q == t) begin
            sb.push_back('{q, 4'h0, 1'b1});
            break;
         end
         nq = d ? q - 4'd1 : q + 4'd1;
         sb.push_back('{q, q ^ nq, 1'b0});
         q = nq;
         k++;
      end
      @(negedge clk);
      start = 1'b1;
      dir = d;
      term_val = t;
      #1;
      chk("pre_t", t_bank, 0);
      @(negedge clk);
      start = 1'b0;
      dir = ~d;
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         e = sb.pop_front();
         stop = (c == stop_at);
         #1;
         chk("run_q", q_bank, e.q);
         chk("run_t", t_bank, e.t);
         chk("run_tc", tc, e.tc);
         chk("run_busy", busy, 1);
         @(negedge clk);
         stop = 1'b0;
      end
      if (sb.size() != 0) chk("sb_timeout", sb.size(), 0);
      sb.delete();
      #1;
      chk("end_done", done, !stopped);
      chk("end_busy", busy, 0);
      chk("end_cnt", run_cnt, k);
      chk("end_q", q_bank, q);
      chk("end_t", t_bank, 0);
      chk("end_tc", tc, 0);
      @(negedge clk);
      #1;
      chk("hold_q", q_bank, q);
      bank_exp = q;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      #1;
      chk("rst_t", t_bank, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tc", tc, 0);
      chk("rst_cnt", run_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      do_load(4'd0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      dir = 1'b0;
      term_val = 4'd15;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("mid_busy", busy, 1);
      chk("mid_q", q_bank, 2);
      rst = 1'b0;
      #1;
      chk("arst_t", t_bank, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_tc", tc, 0);
      chk("arst_cnt", run_cnt, 0);
      @(negedge clk);
      #1;
      chk("arst_freeze", q_bank, 2);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("arst_idle", busy, 0);
      chk("arst_q", q_bank, 2);
      bank_exp = 4'd2;
      run_case(1'b1, 4'd3, 4'd7, 1'b0, -1);
      run_case(1'b0, bank_exp, 4'd7, 1'b0, -1);
      run_case(1'b1, 4'd2, 4'd14, 1'b1, -1);
      run_case(1'b1, 4'd0, 4'd9, 1'b0, 3);
      run_case(1'b1, 4'd14, 4'd1, 1'b0, -1);
      do_load(4'd5, 1'b1);
      @(negedge clk);
      #1;
      chk("ls_idle", busy, 0);
      chk("ls_done", done, 0);
      chk("ls_q", q_bank, 5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
